// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED activity stretcher.
package led_stretch_pkg;

    // Per-channel stretcher state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: two-flop resynchroniser, IDLE/ON/HOLD stretcher FSM,
// hold-tick counter and the channel's output flop.
module led_stretch_chan
    import led_stretch_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 50
) (
    input  logic clock,
    input  logic resn,
    input  logic led_in,
    input  logic tick,
    input  logic lamp_test,
    input  logic dim_gate,
    output logic led
);

    localparam int unsigned CW = clog2_min1(HOLD_TICKS + 1);

    logic        sync1;
    logic        s_in;
    chan_state_t state;
    chan_state_t state_next_c;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next_c;

    // Next state and hold count; a fresh input level always wins over a tick.
    always_comb begin
        state_next_c = state;
        cnt_next_c   = cnt;
        case (state)
            ST_IDLE: begin
                if (s_in) state_next_c = ST_ON;
            end
            ST_ON: begin
                cnt_next_c = CW'(HOLD_TICKS);
                if (!s_in) state_next_c = (HOLD_TICKS == 0) ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (s_in) begin
                    state_next_c = ST_ON;
                end else if (tick) begin
                    if (cnt == CW'(1)) state_next_c = ST_IDLE;
                    else               cnt_next_c   = cnt - CW'(1);
                end
            end
            default: state_next_c = ST_IDLE;
        endcase
    end

    // Synchroniser, FSM state, counter and the LED drive flop.
    always_ff @(posedge clock) begin
        if (!resn) begin
            sync1 <= 1'b0;
            s_in  <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            led   <= 1'b0;
        end else begin
            sync1 <= led_in;
            s_in  <= sync1;
            state <= state_next_c;
            cnt   <= cnt_next_c;
            led   <= lamp_test
                   | (state_next_c == ST_ON)
                   | ((state_next_c == ST_HOLD) & dim_gate);
        end
    end

endmodule

// File: rtl/led_stretch.sv
// LED activity stretcher: resynchronises cog_led into the clock domain and
// holds each LED lit for a minimum visible time after activity.
// Optional feature: define LED_STRETCH_PWM_EN to dim LEDs in HOLD to 25% duty.
module led_stretch
    import led_stretch_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TICK_DIV   = 160000,
    parameter int unsigned HOLD_TICKS = 50
) (
    input  logic             clock,
    input  logic             resn,
    input  logic [WIDTH-1:0] led_in,
    input  logic             lamp_test,
    output logic [WIDTH-1:0] led_out,
    output logic             tick
);

    localparam int unsigned PW = clog2_min1(TICK_DIV);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next_c;
    logic          dim_gate_c;

    // Free-running prescaler wrapping at TICK_DIV-1.
    always_comb begin
        prescaler_next_c = (prescaler == PW'(TICK_DIV - 1)) ? '0 : prescaler + PW'(1);
    end

    // Prescaler register and tick strobe aligned with prescaler==TICK_DIV-1.
    always_ff @(posedge clock) begin
        if (!resn) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            prescaler <= prescaler_next_c;
            tick      <= (prescaler_next_c == PW'(TICK_DIV - 1));
        end
    end

`ifdef LED_STRETCH_PWM_EN
    // HOLD channels light only on prescaler phase 0 of each group of four.
    assign dim_gate_c = (2'(prescaler_next_c) == 2'd0);
`else
    assign dim_gate_c = 1'b1;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        led_stretch_chan #(
            .HOLD_TICKS(HOLD_TICKS)
        ) u_chan (
            .clock    (clock),
            .resn     (resn),
            .led_in   (led_in[i]),
            .tick     (tick),
            .lamp_test(lamp_test),
            .dim_gate (dim_gate_c),
            .led      (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_stretch.sv
// Bench for led_stretch: vector table, behavioural scoreboard and directed
// multi-cycle sequences (stretch length, retrigger, reset mid-hold, HOLD_TICKS=0).
module tb_led_stretch;

    localparam int D = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       resn;
    logic [7:0] led_in, led_in0;
    logic       lamp, lamp0;
    logic [7:0] led_out, led_out0;
    logic       tick, tick0;

    always #5 clk = ~clk;

    led_stretch #(.WIDTH(8), .TICK_DIV(D), .HOLD_TICKS(H)) dut (
        .clock(clk), .resn(resn), .led_in(led_in), .lamp_test(lamp),
        .led_out(led_out), .tick(tick));

    led_stretch #(.WIDTH(8), .TICK_DIV(D), .HOLD_TICKS(0)) dut0 (
        .clock(clk), .resn(resn), .led_in(led_in0), .lamp_test(lamp0),
        .led_out(led_out0), .tick(tick0));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: states 0=idle 1=on 2=hold, remaining ticks in m_cnt.
    logic [7:0] m_s1 = '0, m_s2 = '0, m0_s1 = '0, m0_s2 = '0;
    int m_st [8];
    int m_cnt[8];
    int m_pre = 0;

    typedef struct {
        logic [7:0] led;
        logic       tk;
        logic [7:0] led0;
    } exp_t;
    exp_t sb_q[$];

    function automatic void model_step();
        exp_t e;
        logic [7:0] s_in;
        logic [7:0] lit;
        if (!resn) begin
            m_s1 = '0; m_s2 = '0; m0_s1 = '0; m0_s2 = '0; m_pre = 0;
            for (int c = 0; c < 8; c++) begin m_st[c] = 0; m_cnt[c] = 0; end
            e.led = '0; e.tk = 1'b0; e.led0 = '0;
        end else begin
            s_in = m_s2; m_s2 = m_s1; m_s1 = led_in;
            for (int c = 0; c < 8; c++) begin
                case (m_st[c])
                    0: if (s_in[c]) m_st[c] = 1;
                    1: begin m_cnt[c] = H; if (!s_in[c]) m_st[c] = 2; end
                    default: begin
                        if (s_in[c]) m_st[c] = 1;
                        else if (m_pre == D - 1) begin
                            m_cnt[c] = m_cnt[c] - 1;
                            if (m_cnt[c] == 0) m_st[c] = 0;
                        end
                    end
                endcase
            end
            m_pre = (m_pre + 1) % D;
            for (int c = 0; c < 8; c++) begin
`ifdef LED_STRETCH_PWM_EN
                lit[c] = (m_st[c] == 1) || (m_st[c] == 2 && (m_pre % 4) == 0);
`else
                lit[c] = (m_st[c] != 0);
`endif
            end
            e.led  = lamp ? 8'hFF : lit;
            e.tk   = (m_pre == D - 1);
            e.led0 = lamp0 ? 8'hFF : m0_s2;
            m0_s2 = m0_s1; m0_s1 = led_in0;
        end
        sb_q.push_back(e);
    endfunction

    always @(posedge clk) model_step();

    // Scoreboard: pop the expectation for the edge just taken.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_led",   32'(led_out),  32'(e.led));
            check("sb_tick",  32'(tick),     32'(e.tk));
            check("sb_led0",  32'(led_out0), 32'(e.led0));
            check("sb_tick0", 32'(tick0),    32'(e.tk));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic       rn;
        logic [7:0] din;
        logic       lt;
        logic [7:0] eled;
        logic       etick;
    } vec_t;
    vec_t vt[16];

    task automatic stretch_test(input int ch, input int w, input string name);
        int   hi = 0;
        int   k  = 0;
        logic done = 1'b0;
        logic [7:0] others;
        led_in[ch] = 1'b1;
        for (int i = 1; i <= 80 && !done; i++) begin
            @(negedge clk);
            if (i == 2) check({name, "_pre_rise"}, 32'(led_out[ch]), 32'd0);
            if (i == 3) begin
                check({name, "_rise"}, 32'(led_out[ch]), 32'd1);
                others = led_out; others[ch] = 1'b0;
                check({name, "_others"}, 32'(others), 32'd0);
            end
            if (i == 3 + w) k = (D - 1 - m_pre + D) % D;
            if (i >= 3) begin
                if (led_out[ch]) hi++;
                else done = 1'b1;
            end
            if (i == w) led_in[ch] = 1'b0;
        end
        check({name, "_len"}, 32'(hi), 32'(w + (H - 1) * D + 1 + k));
        check({name, "_range"}, 32'((hi - w >= (H - 1) * D + 1) && (hi - w <= H * D)), 32'd1);
    endtask

    initial begin
        int   lows;
        logic found;
        logic [7:0] drv[40];

        // Reset with inputs high, then free-running ticks and lamp test.
        for (int i = 0; i < 5; i++)  vt[i] = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0};
        for (int i = 5; i < 13; i++) vt[i] = '{1'b1, 8'h00, 1'b0, 8'h00, ((i - 5) % 4) == 2};
        vt[13] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1'b0};
        vt[14] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1};

        led_in0 = '0; lamp0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            resn = vt[i].rn; led_in = vt[i].din; lamp = vt[i].lt;
            @(negedge clk);
            check($sformatf("vec%0d_led", i),  32'(led_out), 32'(vt[i].eled));
            check($sformatf("vec%0d_tick", i), 32'(tick),    32'(vt[i].etick));
        end

`ifndef LED_STRETCH_PWM_EN
        // Single-cycle pulse and a long pulse.
        stretch_test(0, 1, "pulse1");
        repeat (20) @(negedge clk);
        stretch_test(3, 20, "long20");
        repeat (20) @(negedge clk);

        // Retrigger on the last tick of the hold.
        led_in[5] = 1'b1; @(negedge clk); led_in[5] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_st[5] == 2 && m_cnt[5] == 1 && m_pre == 1) found = 1'b1;
        end
        check("retrig_found", 32'(found), 32'd1);
        led_in[5] = 1'b1;
        lows = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) led_in[5] = 1'b0;
            if (i <= 14 && !led_out[5]) lows++;
            if (i == 15) check("retrig_end", 32'(led_out[5]), 32'd0);
        end
        check("retrig_no_glitch", 32'(lows), 32'd0);
        repeat (4) @(negedge clk);
`else
        // Dimmed HOLD: lit only on prescaler phase 0.
        led_in[2] = 1'b1; @(negedge clk); led_in[2] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (m_st[2] == 2) check("pwm_hold", 32'(led_out[2]), 32'(m_pre == 0));
        end
        repeat (6) @(negedge clk);
`endif

        // HOLD_TICKS=0 instance: pure 3-clock delay, then lamp test.
        for (int i = 0; i < 40; i++) begin
            drv[i] = 8'($urandom);
            led_in0 = drv[i];
            @(negedge clk);
            if (i >= 2) check($sformatf("pass%0d", i), 32'(led_out0), 32'(drv[i - 2]));
        end
        led_in0 = '0;
        lamp0 = 1'b1;
        @(negedge clk);
        check("lamp0_on", 32'(led_out0), 32'hFF);
        lamp0 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a hold drops the LED at once.
        led_in[1] = 1'b1; @(negedge clk); led_in[1] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_st[1] == 2) found = 1'b1;
        end
        check("rst_hold_found", 32'(found), 32'd1);
        @(negedge clk);
`ifndef LED_STRETCH_PWM_EN
        check("rst_pre_lit", 32'(led_out[1]), 32'd1);
`endif
        resn = 1'b0;
        @(negedge clk);
        check("rst_drop", 32'(led_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        resn = 1'b1;
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led_out != 8'h00) lows++;
        end
        check("rst_no_stretch", 32'(lows), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
